// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the multiply/divide command path and the sequencer FSM.
package muldiv_sequencer_pkg;

  // Command encoding shared with the mult/div unit's command input.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_DIV  = 2'd1,
    OP_MULT = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam int unsigned MULT_CYCLES_DEF = 32;
  localparam int unsigned DIV_CYCLES_DEF  = 32;
  localparam int unsigned CNT_W_DEF       = 6;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Control-unit and mult/div-unit signals of the sequencer, bundled.
// master: the sequencer itself; slave: control unit plus mult/div unit.
interface muldiv_sequencer_if;
  import muldiv_sequencer_pkg::*;

  logic        op_valid;
  op_e         op;
  logic [31:0] opnd_b;
  op_e         unit_ctrl;
  logic [31:0] unit_hi;
  logic [31:0] unit_lo;
  logic        unit_div0;
  logic        busy;
  logic        done;
  logic        div0_exc;
  logic        rd_sel;
  logic [31:0] rd_data;

  modport master (
    input  op_valid, op, opnd_b, unit_hi, unit_lo, unit_div0, rd_sel,
    output unit_ctrl, busy, done, div0_exc, rd_data
  );

  modport slave (
    output op_valid, op, opnd_b, unit_hi, unit_lo, unit_div0, rd_sel,
    input  unit_ctrl, busy, done, div0_exc, rd_data
  );

endinterface

// File: rtl/muldiv_sequencer.sv
// Initiator side of the multiply/divide unit: sequences one operation at a
// time, holds the architectural HI/LO and flags divide-by-zero.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for a request; zero-divisor DIV rejected here
//   RUN     | command driven to the unit, counter running down to 0
//   CAPTURE | command held; next edge writes HI/LO and pulses done
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,   // asynchronous, active low
  muldiv_sequencer_if.master  mdu
);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  op_e               r_ctrl;
  logic [31:0]       r_hi;
  logic [31:0]       r_lo;
  logic              r_busy;
  logic              r_done;
  logic              r_div0;

  logic              w_b_zero;

  assign w_b_zero = (mdu.opnd_b == 32'd0);

  // Sequencer FSM with in-line down-counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ctrl  <= OP_NONE;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mdu.op_valid) begin
            if (mdu.op == OP_MULT) begin
              r_cnt   <= CNT_W'(MULT_CYCLES - 1);
              r_ctrl  <= OP_MULT;
              r_busy  <= 1'b1;
              r_state <= RUN;
            end else if (mdu.op == OP_DIV) begin
              if (w_b_zero) begin
                // Rejected before the unit ever sees a command.
                r_div0 <= 1'b1;
              end else begin
                r_cnt   <= CNT_W'(DIV_CYCLES - 1);
                r_ctrl  <= OP_DIV;
                r_busy  <= 1'b1;
                r_state <= RUN;
              end
            end
          end
        end
        RUN: begin
          // A unit-reported divide-by-zero wins over reaching terminal count.
          if (mdu.unit_div0) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ctrl  <= OP_NONE;
            r_busy  <= 1'b0;
            r_div0  <= 1'b1;
          end else if (r_cnt == '0) begin
            r_state <= CAPTURE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        CAPTURE: begin
          r_hi    <= mdu.unit_hi;
          r_lo    <= mdu.unit_lo;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_ctrl  <= OP_NONE;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_ctrl  <= OP_NONE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu.unit_ctrl = r_ctrl;
  assign mdu.busy      = r_busy;
  assign mdu.done      = r_done;
  assign mdu.div0_exc  = r_div0;
  // Reads straight from the registers, so the value written on the done
  // edge is already visible during the done cycle.
  assign mdu.rd_data   = mdu.rd_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed scenarios plus random
// operations, checked against a cycle-count model of the operation timeline
// and a behavioural mult/div unit.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int N_MUL = 32;
  localparam int N_DIV = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(
    .MULT_CYCLES (N_MUL),
    .DIV_CYCLES  (N_DIV),
    .CNT_W       (6)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .mdu   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd();
    bus.rd_sel = 1'b0;
    #1;
    chk("rd_lo", bus.rd_data, m_lo);
    bus.rd_sel = 1'b1;
    #1;
    chk("rd_hi", bus.rd_data, m_hi);
    bus.rd_sel = 1'b0;
  endtask

  // Behavioural mult/div unit: signed product / signed quotient+remainder.
  task automatic unit_result(input op_e op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] hi, output logic [31:0] lo);
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = 32'd0;
    lo = 32'd0;
    if (op == OP_MULT) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (sb != 0) begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endtask

  // Issue one op and check every cycle of its timeline. t counts edges after
  // the accepting edge; outputs are sampled 1 time unit after each edge.
  task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input int junk_at, input int abort_at,
                        input bit chain, input op_e nxt_op, input logic [31:0] nxt_b,
                        output int done_cyc);
    int n;
    logic [31:0] hi;
    logic [31:0] lo;
    n = (op == OP_MULT) ? N_MUL : N_DIV;
    unit_result(op, a, b, hi, lo);
    done_cyc      = -1;
    bus.op_valid  = 1'b1;
    bus.op        = op;
    bus.opnd_b    = b;
    bus.unit_hi   = hi;
    bus.unit_lo   = lo;
    bus.unit_div0 = 1'b0;
    if (op == OP_DIV && b == 32'd0) begin
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      chk("dz_exc", bus.div0_exc, 1'b1);
      chk("dz_busy", bus.busy, 1'b0);
      chk("dz_ctrl", bus.unit_ctrl, OP_NONE);
      chk("dz_done", bus.done, 1'b0);
      @(posedge clk); #1;
      chk("dz_exc_end", bus.div0_exc, 1'b0);
      chk("dz_busy2", bus.busy, 1'b0);
      chk("dz_ctrl2", bus.unit_ctrl, OP_NONE);
      chk_rd();
      return;
    end
    for (int t = 0; t <= n + 1; t++) begin
      @(posedge clk); #1;
      if (abort_at >= 0 && t == abort_at + 1) begin
        bus.unit_div0 = 1'b0;
        chk("ab_busy", bus.busy, 1'b0);
        chk("ab_ctrl", bus.unit_ctrl, OP_NONE);
        chk("ab_exc", bus.div0_exc, 1'b1);
        chk("ab_done", bus.done, 1'b0);
        @(posedge clk); #1;
        chk("ab_exc_end", bus.div0_exc, 1'b0);
        chk("ab_busy2", bus.busy, 1'b0);
        chk_rd();
        return;
      end
      chk("busy", bus.busy, (t <= n));
      chk("ctrl", bus.unit_ctrl, (t <= n) ? op : OP_NONE);
      chk("done", bus.done, (t == n + 1));
      chk("div0_exc", bus.div0_exc, 1'b0);
      if (t == n + 1) begin
        m_hi     = hi;
        m_lo     = lo;
        done_cyc = cyc;
        chk_rd();
      end
      if (t == 0) begin
        if (chain) begin
          bus.op     = nxt_op;
          bus.opnd_b = nxt_b;
        end else begin
          bus.op_valid = 1'b0;
        end
      end
      if (t == junk_at) begin
        bus.op_valid = 1'b1;
        bus.op       = OP_MULT;
        bus.opnd_b   = $urandom;
      end
      if (t == junk_at + 1 && !chain) bus.op_valid = 1'b0;
      if (abort_at >= 0 && t == abort_at) bus.unit_div0 = 1'b1;
    end
  endtask

  // Idle cycles with none/reserved ops on the request lines: nothing starts.
  task automatic idle_gap(input int k);
    for (int i = 0; i < k; i++) begin
      bus.op_valid = 1'($urandom_range(0, 1));
      bus.op       = ($urandom_range(0, 1) != 0) ? OP_RSVD : OP_NONE;
      bus.opnd_b   = $urandom;
      @(posedge clk); #1;
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_ctrl", bus.unit_ctrl, OP_NONE);
      chk("idle_done", bus.done, 1'b0);
      chk("idle_exc", bus.div0_exc, 1'b0);
    end
    bus.op_valid = 1'b0;
    bus.op       = OP_NONE;
  endtask

  initial begin
    int d1;
    int d2;
    int dmy;
    int junk;
    int abrt;
    int r;
    op_e o;
    logic [31:0] a;
    logic [31:0] b;

    rst_n         = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op        = OP_NONE;
    bus.opnd_b    = 32'd0;
    bus.unit_hi   = 32'd0;
    bus.unit_lo   = 32'd0;
    bus.unit_div0 = 1'b0;
    bus.rd_sel    = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;

    // Reset state
    #2;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_exc", bus.div0_exc, 1'b0);
    chk("rst_ctrl", bus.unit_ctrl, OP_NONE);
    chk_rd();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle_gap(2);

    // MULT 7 * -3
    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, -1, -1, 1'b0, OP_NONE, 32'd0, dmy);
    bus.rd_sel = 1'b1; #1;
    chk("mult_hi_const", bus.rd_data, 32'hFFFF_FFFF);
    bus.rd_sel = 1'b0; #1;
    chk("mult_lo_const", bus.rd_data, 32'hFFFF_FFEB);

    // DIV 100 / 7
    run_op(OP_DIV, 32'd100, 32'd7, -1, -1, 1'b0, OP_NONE, 32'd0, dmy);
    bus.rd_sel = 1'b0; #1;
    chk("div_lo_const", bus.rd_data, 32'h0000_000E);
    bus.rd_sel = 1'b1; #1;
    chk("div_hi_const", bus.rd_data, 32'h0000_0002);
    bus.rd_sel = 1'b0;

    // Preload HI=5, LO=9 (68/7), then divide by zero leaves them untouched
    run_op(OP_DIV, 32'd68, 32'd7, -1, -1, 1'b0, OP_NONE, 32'd0, dmy);
    run_op(OP_DIV, 32'd1234, 32'd0, -1, -1, 1'b0, OP_NONE, 32'd0, dmy);
    bus.rd_sel = 1'b1; #1;
    chk("dz_hi_const", bus.rd_data, 32'd5);
    bus.rd_sel = 1'b0; #1;
    chk("dz_lo_const", bus.rd_data, 32'd9);
    idle_gap(2);

    // MULT request pulsed in the middle of a DIV is ignored
    run_op(OP_DIV, 32'd200, 32'd9, 12, -1, 1'b0, OP_NONE, 32'd0, dmy);
    idle_gap(4);

    // Reset mid-run when the counter reads 10
    bus.op_valid = 1'b1;
    bus.op       = OP_DIV;
    bus.opnd_b   = 32'd3;
    bus.unit_hi  = 32'hDEAD_BEEF;
    bus.unit_lo  = 32'hCAFE_F00D;
    for (int t = 0; t <= N_DIV - 11; t++) begin
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      chk("rr_busy", bus.busy, 1'b1);
      chk("rr_ctrl", bus.unit_ctrl, OP_DIV);
    end
    rst_n = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    #1;
    chk("rr_busy0", bus.busy, 1'b0);
    chk("rr_ctrl0", bus.unit_ctrl, OP_NONE);
    chk("rr_done0", bus.done, 1'b0);
    chk("rr_exc0", bus.div0_exc, 1'b0);
    chk_rd();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int t = 0; t < N_DIV + 4; t++) begin
      @(posedge clk); #1;
      chk("rr_no_done", bus.done, 1'b0);
      chk("rr_no_exc", bus.div0_exc, 1'b0);
      chk("rr_idle", bus.busy, 1'b0);
    end
    chk_rd();

    // Back-to-back MULT then DIV with op_valid held high
    run_op(OP_MULT, 32'd123456, 32'hFFFF_0001, -1, -1, 1'b1, OP_DIV, 32'd17, d1);
    run_op(OP_DIV, 32'd99999, 32'd17, -1, -1, 1'b0, OP_NONE, 32'd0, d2);
    chk("b2b_spacing", 32'(d2 - d1), 32'(N_MUL + 2));

    // Directed unit divide-by-zero abort early in RUN
    run_op(OP_DIV, 32'd50, 32'd5, -1, 3, 1'b0, OP_NONE, 32'd0, dmy);
    idle_gap(1);

    // Random operations
    for (int i = 0; i < 16; i++) begin
      o = ($urandom_range(0, 1) != 0) ? OP_MULT : OP_DIV;
      a = $urandom;
      b = $urandom;
      if (o == OP_DIV && $urandom_range(0, 3) == 0) b = 32'd0;
      junk = -1;
      abrt = -1;
      r = $urandom_range(0, 3);
      if (r == 1) junk = $urandom_range(0, ((o == OP_MULT) ? N_MUL : N_DIV) - 1);
      else if (r == 2 && o == OP_DIV) abrt = $urandom_range(0, N_DIV - 1);
      run_op(o, a, b, junk, abrt, 1'b0, OP_NONE, 32'd0, dmy);
      idle_gap($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
